uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART byte transmitter (8N1, single-byte enable/done handshake) between NUM_REQ requesters.
- Grants are round-robin. The arbiter latches the winner's byte and issues a one-cycle transmit enable.
- It tracks the transmitter's active/done flags, returns a per-requester ack, and keeps the next launch off the line until the transmitter is back in idle.
- Sits between on-chip byte producers and the UART TX core. It is the only driver of the transmitter's enable and data inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT_DONE before the transaction is aborted as a timeout.

Ports:
- in_UART_Clock  input  1  clock, same domain as the UART TX core.
- in_Reset_n  input  1  asynchronous, active-low reset.
- in_Req  input  NUM_REQ  per-requester transmit request, level.
- in_Req_Data  input  8*NUM_REQ  byte for requester i on bits [8i+7:8i].
- out_Grant  output  NUM_REQ  one-hot; identifies the requester currently being served.
- out_Ack  output  NUM_REQ  one-cycle pulse when the granted byte's stop bit has completed.
- out_Busy  output  1  high whenever the state is not ARB.
- out_Timeout_Err  output  1  sticky; set on timeout abort.
- in_Err_Clear  input  1  synchronous clear of out_Timeout_Err.
- out_Tx_En  output  1  to transmitter enable.
- out_Tx_8bitData  output  8  to transmitter data.
- in_Tx_Active  input  1  from transmitter active flag.
- in_Tx_Done  input  1  from transmitter done flag.

Behaviour:
- Reset (async, in_Reset_n=0):
  - State ARB, RR pointer 0, timeout counter 0.
  - All outputs 0: out_Grant, out_Ack, out_Tx_En, out_Tx_8bitData, out_Busy, out_Timeout_Err.
  - A reset asserted mid-transaction abandons it silently; no ack is issued.
- All outputs are registered.
- ARB:
  - If any in_Req is high, pick the first set bit searching upward from the pointer, wrapping modulo NUM_REQ.
  - Next edge: out_Grant one-hot = winner, out_Tx_8bitData = winner's byte, out_Tx_En = 1, state LAUNCH.
  - With no request, stay in ARB with all outputs idle.
- LAUNCH (exactly 1 cycle):
  - out_Tx_En returns to 0 at the next edge; state WAIT_DONE; timeout counter cleared.
- WAIT_DONE:
  - Counter increments each cycle.
  - On in_Tx_Done=1: out_Ack[winner] pulses for 1 cycle; state WAIT_CLR.
  - If the counter reaches TIMEOUT_CYCLES first: no ack, out_Timeout_Err <= 1; state WAIT_CLR.
  - in_Tx_Active is monitored only; done is the completion criterion.
- WAIT_CLR:
  - Hold until in_Tx_Done=0, which indicates the transmitter is back in idle and able to sample enable.
  - Then clear out_Grant, set pointer = winner+1 mod NUM_REQ, state ARB.
  - Minimum gap between consecutive out_Tx_En pulses is therefore set by the transmitter's done deassertion, not a fixed count.
- Data is latched at grant. Changes to in_Req_Data or a drop of in_Req after grant do not affect the byte in flight; an ack is still issued.
- Requester contract:
  - Hold in_Req high until ack.
  - Drop in_Req within 1 cycle after ack; a request still high when ARB is re-entered is treated as a new request.
  - The done flag stays high for at least 2 cycles after ack, which guarantees this window.
- Simultaneous events:
  - in_Err_Clear in the same cycle as a timeout: set wins.
  - Multiple requests: only one is granted per arbitration; requests arriving during a transaction wait for ARB.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0,...
- Out-of-range NUM_REQ is not supported.

Test Plan:
- Single request, transmitter model with CLKS_PER_BIT=1:
  - in_Req=0001, data[7:0]=0xA5.
  - Required: out_Grant=0001 and out_Tx_En high for exactly 1 cycle with out_Tx_8bitData=0xA5.
  - Serial line carries 0, 1,0,1,0,0,1,0,1 (LSB first), then 1.
  - out_Ack[0] pulses once when done rises; out_Busy falls after done clears.
- All four requesting continuously, bytes 0x11/0x22/0x33/0x44:
  - Required: launch order 0x11, 0x22, 0x33, 0x44, 0x11.
  - Exactly one ack per launch, matching out_Grant.
- Requester 2 changes its data and drops in_Req one cycle after grant:
  - Required: original byte transmitted; out_Ack[2] still pulsed.
- Transmitter model never asserts done, TIMEOUT_CYCLES=16:
  - Required: out_Timeout_Err set after 16 WAIT_DONE cycles; no ack; grant released; next requester served.
  - in_Err_Clear then clears the flag.
- Back-to-back requests from requester 1:
  - Required: second out_Tx_En only after in_Tx_Done has returned to 0; the transmitter accepts both bytes with no lost enable.
- in_Reset_n pulled low during the data bits:
  - Required: all outputs 0 asynchronously; pointer 0; no ack.
  - After release and a transmitter reset, a new request for requester 0 is served normally.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one 8N1 UART byte transmitter
// between NUM_REQ byte producers. The winner's byte is latched at grant, a
// one-cycle enable launches it, and the transaction completes on the
// transmitter's done flag (or aborts after TIMEOUT_CYCLES). The next launch
// is held off until done has dropped again.
//
// Ports:
//   in_UART_Clock / in_Reset_n   clock, asynchronous active-low reset
//   in_Req, in_Req_Data          per-requester level request and byte
//   out_Grant, out_Ack           one-hot grant, one-cycle completion ack
//   out_Busy, out_Timeout_Err    not-idle flag, sticky timeout flag
//   in_Err_Clear                 synchronous clear of the timeout flag
//   out_Tx_En, out_Tx_8bitData   transmitter launch strobe and byte
//   in_Tx_Active, in_Tx_Done     transmitter status flags
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   in_UART_Clock,
    input  logic                   in_Reset_n,
    input  logic [NUM_REQ-1:0]     in_Req,
    input  logic [8*NUM_REQ-1:0]   in_Req_Data,
    output logic [NUM_REQ-1:0]     out_Grant,
    output logic [NUM_REQ-1:0]     out_Ack,
    output logic                   out_Busy,
    output logic                   out_Timeout_Err,
    input  logic                   in_Err_Clear,
    output logic                   out_Tx_En,
    output logic [7:0]             out_Tx_8bitData,
    input  logic                   in_Tx_Active,
    input  logic                   in_Tx_Done
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_ARB       = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_WAIT_CLR  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               tx_en_q, tx_en_d;
    logic [7:0]         tx_data_q, tx_data_d;

    logic               any_req_c;
    logic [IDX_W-1:0]   pick_c;
    logic               timeout_c;
    logic [IDX_W-1:0]   ptr_next_c;
    logic [7:0]         req_byte_c [NUM_REQ];

    // Transmitter activity is observed only; completion is judged by done.
    logic               tx_active_unused;
    assign tx_active_unused = in_Tx_Active;

    // Split the flat data bus into per-requester bytes.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_byte_c[i] = in_Req_Data[8*i +: 8];
        end
    end

    // Round-robin pick: first set request searching upward from ptr_q, wrapping.
    always_comb begin
        logic [IDX_W:0] idx;
        any_req_c = 1'b0;
        pick_c    = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (idx >= (IDX_W+1)'(NUM_REQ)) begin
                idx = idx - (IDX_W+1)'(NUM_REQ);
            end
            if (!any_req_c && in_Req[idx[IDX_W-1:0]]) begin
                any_req_c = 1'b1;
                pick_c    = idx[IDX_W-1:0];
            end
        end
    end

    // The abort fires at the end of the TIMEOUT_CYCLES-th WAIT_DONE cycle.
    assign timeout_c  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign ptr_next_c = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

    // State and output registers.
    always_ff @(posedge in_UART_Clock or negedge in_Reset_n) begin
        if (!in_Reset_n) begin
            state_q   <= ST_ARB;
            ptr_q     <= '0;
            win_q     <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            ack_q     <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:       if (any_req_c) state_d = ST_LAUNCH;
            ST_LAUNCH:    state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (in_Tx_Done || timeout_c) state_d = ST_WAIT_CLR;
            ST_WAIT_CLR:  if (!in_Tx_Done) state_d = ST_ARB;
            default:      state_d = ST_ARB;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        grant_d   = grant_q;
        ack_d     = '0;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        err_d     = err_q;

        // A timeout in the same cycle as a clear overrides it below.
        if (in_Err_Clear) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_ARB: begin
                if (any_req_c) begin
                    grant_d   = NUM_REQ'(1'b1) << pick_c;
                    tx_data_d = req_byte_c[pick_c];
                    tx_en_d   = 1'b1;
                    win_d     = pick_c;
                end
            end
            ST_LAUNCH: begin
                cnt_d = '0;
            end
            ST_WAIT_DONE: begin
                cnt_d = cnt_q + 1'b1;
                if (in_Tx_Done) begin
                    ack_d = grant_q;
                end else if (timeout_c) begin
                    err_d = 1'b1;
                end
            end
            ST_WAIT_CLR: begin
                if (!in_Tx_Done) begin
                    grant_d   = '0;
                    tx_data_d = '0;
                    ptr_d     = ptr_next_c;
                end
            end
            default: begin
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != ST_ARB);
    end

    assign out_Grant       = grant_q;
    assign out_Ack         = ack_q;
    assign out_Busy        = busy_q;
    assign out_Timeout_Err = err_q;
    assign out_Tx_En       = tx_en_q;
    assign out_Tx_8bitData = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a behavioural 8N1 transmitter (one clock per
// bit, done held for three cycles after the stop bit) sits behind the
// arbiter. Table vectors cover arbitration order; hand sequences cover
// timing, data latching, timeout, back-to-back and mid-frame reset.
module tb_uart_tx_arbiter;

    localparam int unsigned N = 4;

    localparam int W_EN      = 0;
    localparam int W_IDLE    = 1;
    localparam int W_DONE_HI = 2;
    localparam int W_DONE_LO = 3;
    localparam int W_ERR     = 4;
    localparam int W_ACK     = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           tx_rst_n;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic           err_clr;
    logic [N-1:0]   grant;
    logic [N-1:0]   ack;
    logic           busy;
    logic           terr;
    logic           tx_en;
    logic [7:0]     tx_data;
    logic           tx_active;
    logic           tx_done;
    logic           serial;

    int checks  = 0;
    int errors  = 0;
    int ack_cnt = 0;
    logic [N-1:0] last_ack = '0;
    logic auto_drop;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .in_UART_Clock   (clk),
        .in_Reset_n      (rst_n),
        .in_Req          (req),
        .in_Req_Data     (req_data),
        .out_Grant       (grant),
        .out_Ack         (ack),
        .out_Busy        (busy),
        .out_Timeout_Err (terr),
        .in_Err_Clear    (err_clr),
        .out_Tx_En       (tx_en),
        .out_Tx_8bitData (tx_data),
        .in_Tx_Active    (tx_active),
        .in_Tx_Done      (tx_done)
    );

    // Behavioural transmitter: accepts enable only in idle.
    typedef enum logic [2:0] {M_IDLE, M_START, M_DATA, M_STOP, M_DONE} mst_t;
    mst_t       m_st;
    int         m_cnt;
    logic [7:0] m_shift;
    logic       hang;
    int         accepted = 0;
    logic       line_q[$];

    always @(posedge clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            m_st      <= M_IDLE;
            m_cnt     <= 0;
            m_shift   <= '0;
            serial    <= 1'b1;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            case (m_st)
                M_IDLE: if (tx_en) begin
                    m_shift   <= tx_data;
                    serial    <= 1'b0;
                    tx_active <= 1'b1;
                    accepted  <= accepted + 1;
                    m_st      <= M_START;
                end
                M_START: begin
                    serial <= m_shift[0];
                    m_cnt  <= 0;
                    m_st   <= M_DATA;
                end
                M_DATA: begin
                    if (m_cnt == 7) begin
                        serial <= 1'b1;
                        m_st   <= M_STOP;
                    end else begin
                        serial <= m_shift[m_cnt+1];
                        m_cnt  <= m_cnt + 1;
                    end
                end
                M_STOP: begin
                    tx_active <= 1'b0;
                    m_cnt     <= 0;
                    if (hang) begin
                        m_st <= M_IDLE;
                    end else begin
                        tx_done <= 1'b1;
                        m_st    <= M_DONE;
                    end
                end
                M_DONE: begin
                    if (m_cnt == 2) begin
                        tx_done <= 1'b0;
                        m_st    <= M_IDLE;
                    end else begin
                        m_cnt <= m_cnt + 1;
                    end
                end
                default: m_st <= M_IDLE;
            endcase
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Line capture, requester drop-on-ack, and continuous protocol checks.
    always @(negedge clk) begin
        if (m_st == M_START || m_st == M_DATA || m_st == M_STOP) line_q.push_back(serial);
        if (auto_drop) begin
            for (int i = 0; i < int'(N); i++) if (ack[i]) req[i] = 1'b0;
        end
        if (ack != '0) begin
            ack_cnt++;
            last_ack = ack;
            check("ack_matches_grant", 32'(ack), 32'(grant));
        end
        if (tx_en) check("en_only_when_tx_idle", 32'({m_st == M_IDLE, tx_done}), 32'(2'b10));
    end

    function automatic logic cond(input int which);
        case (which)
            W_EN:      return tx_en;
            W_IDLE:    return !busy;
            W_DONE_HI: return tx_done;
            W_DONE_LO: return !tx_done;
            W_ERR:     return terr;
            W_ACK:     return (ack != '0);
            default:   return 1'b1;
        endcase
    endfunction

    task automatic wait_for(input int which, input int limit, input string nm, output int cyc);
        cyc = 0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            cyc++;
            if (cond(which)) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: wait timed out after %0d cycles", nm, limit);
    endtask

    task automatic check_frame(input int base, input logic [7:0] d, input string nm);
        logic [9:0] got;
        if (line_q.size() < base + 10) begin
            checks++;
            errors++;
            $display("FAIL %s: line has %0d bits, need %0d", nm, line_q.size(), base + 10);
            return;
        end
        for (int k = 0; k < 10; k++) got[k] = line_q[base+k];
        check(nm, 32'(got), 32'({1'b1, d, 1'b0}));
    endtask

    task automatic run_txn(input logic [N-1:0] r, input logic [N-1:0] eg,
                           input logic [7:0] ed, input string nm);
        int c;
        int a0;
        a0 = ack_cnt;
        @(negedge clk);
        req = r;
        wait_for(W_EN, 40, {nm, "_en"}, c);
        check({nm, "_grant"}, 32'(grant), 32'(eg));
        check({nm, "_data"}, 32'(tx_data), 32'(ed));
        wait_for(W_IDLE, 60, {nm, "_idle"}, c);
        req = '0;
        check({nm, "_ackcnt"}, 32'(ack_cnt - a0), 32'd1);
        check({nm, "_ack"}, 32'(last_ack), 32'(eg));
    endtask

    typedef struct packed {
        logic [N-1:0] req;
        logic [N-1:0] exp_grant;
        logic [7:0]   exp_data;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int c;
        int a0;
        int acc0;
        logic [7:0] cont_d [5];

        // Arbitration vectors applied in order from pointer 1.
        vecs[0] = '{req: 4'b0001, exp_grant: 4'b0001, exp_data: 8'h11};
        vecs[1] = '{req: 4'b1111, exp_grant: 4'b0010, exp_data: 8'h22};
        vecs[2] = '{req: 4'b0001, exp_grant: 4'b0001, exp_data: 8'h11};
        vecs[3] = '{req: 4'b1001, exp_grant: 4'b1000, exp_data: 8'h44};
        vecs[4] = '{req: 4'b0110, exp_grant: 4'b0010, exp_data: 8'h22};
        vecs[5] = '{req: 4'b0011, exp_grant: 4'b0001, exp_data: 8'h11};
        vecs[6] = '{req: 4'b1100, exp_grant: 4'b0100, exp_data: 8'h33};
        vecs[7] = '{req: 4'b1111, exp_grant: 4'b1000, exp_data: 8'h44};
        cont_d[0] = 8'h11; cont_d[1] = 8'h22; cont_d[2] = 8'h33;
        cont_d[3] = 8'h44; cont_d[4] = 8'h11;

        rst_n = 1'b0; tx_rst_n = 1'b0; req = '0; err_clr = 1'b0;
        hang = 1'b0; auto_drop = 1'b1;
        req_data = {8'h44, 8'h33, 8'h22, 8'hA5};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(terr), 32'd0);
        check("rst_en", 32'(tx_en), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        rst_n = 1'b1; tx_rst_n = 1'b1;

        // Single request: timing of enable, ack and busy, plus the line frame.
        line_q.delete();
        @(negedge clk);
        req = 4'b0001;
        wait_for(W_EN, 20, "single_en", c);
        check("single_grant", 32'(grant), 32'h1);
        check("single_data", 32'(tx_data), 32'hA5);
        @(negedge clk);
        check("single_en_one_cycle", 32'(tx_en), 32'd0);
        wait_for(W_DONE_HI, 40, "single_done", c);
        @(negedge clk);
        check("single_ack_pulse", 32'(ack), 32'h1);
        @(negedge clk);
        check("single_ack_ends", 32'(ack), 32'h0);
        wait_for(W_DONE_LO, 20, "single_done_lo", c);
        check("single_busy_while_done", 32'(busy), 32'd1);
        @(negedge clk);
        check("single_busy_falls", 32'(busy), 32'd0);
        check_frame(0, 8'hA5, "single_frame");

        // Table-driven arbitration order.
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].req, vecs[i].exp_grant, vecs[i].exp_data, $sformatf("vec%0d", i));
        end

        // All four requesting continuously: rotation from pointer 0.
        auto_drop = 1'b0;
        a0 = ack_cnt;
        @(negedge clk);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_for(W_EN, 60, "rot_en", c);
            check($sformatf("rot%0d_data", k), 32'(tx_data), 32'(cont_d[k]));
            check($sformatf("rot%0d_grant", k), 32'(grant), 32'(4'b0001 << (k % 4)));
        end
        req = '0;
        wait_for(W_IDLE, 60, "rot_idle", c);
        check("rot_ackcnt", 32'(ack_cnt - a0), 32'd5);
        auto_drop = 1'b1;

        // Requester 2 changes data and drops its request after grant.
        req_data[23:16] = 8'h5C;
        line_q.delete();
        a0 = ack_cnt;
        @(negedge clk);
        req = 4'b0100;
        wait_for(W_EN, 20, "chg_en", c);
        check("chg_grant", 32'(grant), 32'h4);
        @(negedge clk);
        req_data[23:16] = 8'hFF;
        req[2] = 1'b0;
        wait_for(W_IDLE, 60, "chg_idle", c);
        check("chg_ackcnt", 32'(ack_cnt - a0), 32'd1);
        check("chg_ack", 32'(last_ack), 32'h4);
        check_frame(0, 8'h5C, "chg_frame");

        // Transmitter never signals done: timeout, no ack, next requester served.
        hang = 1'b1;
        a0 = ack_cnt;
        @(negedge clk);
        req = 4'b1010;
        wait_for(W_EN, 20, "to_en", c);
        check("to_grant", 32'(grant), 32'h8);
        wait_for(W_ERR, 40, "to_err", c);
        check("to_cycles", 32'(c), 32'd17);
        check("to_no_ack", 32'(ack_cnt - a0), 32'd0);
        hang = 1'b0;
        req[3] = 1'b0;
        @(negedge clk);
        check("to_grant_released", 32'(grant), 32'h0);
        wait_for(W_EN, 20, "to_next_en", c);
        check("to_next_grant", 32'(grant), 32'h2);
        check("to_next_data", 32'(tx_data), 32'h22);
        wait_for(W_IDLE, 60, "to_next_idle", c);
        req = '0;
        check("to_next_ack", 32'(last_ack), 32'h2);
        check("to_ackcnt", 32'(ack_cnt - a0), 32'd1);
        check("to_err_sticky", 32'(terr), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("to_err_cleared", 32'(terr), 32'd0);

        // Back-to-back bytes from requester 1.
        req_data[15:8] = 8'h3C;
        line_q.delete();
        a0 = ack_cnt;
        acc0 = accepted;
        @(negedge clk);
        req = 4'b0010;
        wait_for(W_EN, 20, "b2b_en1", c);
        check("b2b_data1", 32'(tx_data), 32'h3C);
        wait_for(W_ACK, 40, "b2b_ack1", c);
        @(negedge clk);
        req_data[15:8] = 8'hC3;
        req[1] = 1'b1;
        wait_for(W_EN, 40, "b2b_en2", c);
        check("b2b_grant2", 32'(grant), 32'h2);
        check("b2b_data2", 32'(tx_data), 32'hC3);
        check("b2b_done_low_at_en", 32'(tx_done), 32'd0);
        wait_for(W_IDLE, 60, "b2b_idle", c);
        req = '0;
        check("b2b_ackcnt", 32'(ack_cnt - a0), 32'd2);
        check("b2b_accepted", 32'(accepted - acc0), 32'd2);
        check_frame(0, 8'h3C, "b2b_frame1");
        check_frame(10, 8'hC3, "b2b_frame2");

        // Reset during the data bits, then service from pointer 0.
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        @(negedge clk);
        req = 4'b1000;
        wait_for(W_EN, 20, "rmid_en", c);
        check("rmid_grant", 32'(grant), 32'h8);
        repeat (4) @(negedge clk);
        a0 = ack_cnt;
        #2;
        rst_n = 1'b0;
        tx_rst_n = 1'b0;
        #1;
        check("rmid_grant0", 32'(grant), 32'd0);
        check("rmid_en0", 32'(tx_en), 32'd0);
        check("rmid_data0", 32'(tx_data), 32'd0);
        check("rmid_busy0", 32'(busy), 32'd0);
        check("rmid_ack0", 32'(ack), 32'd0);
        check("rmid_err0", 32'(terr), 32'd0);
        repeat (3) @(negedge clk);
        check("rmid_no_ack", 32'(ack_cnt - a0), 32'd0);
        rst_n = 1'b1;
        tx_rst_n = 1'b1;
        req_data = {8'h44, 8'h77, 8'h22, 8'h96};
        req = 4'b0101;
        wait_for(W_EN, 20, "rpost_en", c);
        check("rpost_grant", 32'(grant), 32'h1);
        check("rpost_data", 32'(tx_data), 32'h96);
        wait_for(W_IDLE, 60, "rpost_idle", c);
        req = '0;
        check("rpost_ackcnt", 32'(ack_cnt - a0), 32'd1);
        check("rpost_ack", 32'(last_ack), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
